// File: rtl/sbox_arbiter.sv
// rtl/sbox_arbiter.sv - two-requester S-Box ROM arbiter with a LAT-deep response tag pipeline
// Optional grant counters are enabled with SBOX_ARB_STATS_EN.
module sbox_arbiter #(
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dp_req_valid,
    input  logic [127:0] dp_req_data,
    output logic         dp_req_ready,
    output logic         dp_rsp_valid,
    output logic [127:0] dp_rsp_data,
    input  logic         ks_req_valid,
    input  logic [31:0]  ks_req_word,
    output logic         ks_req_ready,
    output logic         ks_rsp_valid,
    output logic [31:0]  ks_rsp_word,
    output logic [127:0] sbox_addr,
    input  logic [127:0] sbox_value
`ifdef SBOX_ARB_STATS_EN
    ,
    output logic [15:0]  dp_grant_cnt,
    output logic [15:0]  ks_grant_cnt
`endif
);

    logic           last_ks_q, last_ks_d;
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_ks_q, tag_ks_d;
    logic           dp_gnt, ks_gnt;

    // last_ks_q low means DP was served last, so a tie goes to KS.
    always_comb begin
        dp_req_ready = !reset && dp_req_valid && (!ks_req_valid || last_ks_q);
        ks_req_ready = !reset && ks_req_valid && (!dp_req_valid || !last_ks_q);
        dp_gnt       = dp_req_valid && dp_req_ready;
        ks_gnt       = ks_req_valid && ks_req_ready;

        last_ks_d = last_ks_q;
        if (dp_gnt) begin
            last_ks_d = 1'b0;
        end else if (ks_gnt) begin
            last_ks_d = 1'b1;
        end

        sbox_addr = '0;
        if (dp_gnt) begin
            sbox_addr = dp_req_data;
        end else if (ks_gnt) begin
            sbox_addr = {96'b0, ks_req_word};
        end

        tag_vld_d    = '0;
        tag_ks_d     = '0;
        tag_vld_d[0] = dp_gnt || ks_gnt;
        tag_ks_d[0]  = ks_gnt;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ks_d[i]  = tag_ks_q[i-1];
        end
    end

    // Gating with reset drops a lookup whose tag is still in flight when reset hits.
    always_comb begin
        dp_rsp_valid = !reset && tag_vld_q[LAT-1] && !tag_ks_q[LAT-1];
        ks_rsp_valid = !reset && tag_vld_q[LAT-1] && tag_ks_q[LAT-1];
        dp_rsp_data  = dp_rsp_valid ? sbox_value : 128'b0;
        ks_rsp_word  = ks_rsp_valid ? sbox_value[31:0] : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ks_q <= 1'b0;
            tag_vld_q <= '0;
            tag_ks_q  <= '0;
        end else begin
            last_ks_q <= last_ks_d;
            tag_vld_q <= tag_vld_d;
            tag_ks_q  <= tag_ks_d;
        end
    end

`ifdef SBOX_ARB_STATS_EN
    logic [15:0] dp_cnt_q, dp_cnt_d;
    logic [15:0] ks_cnt_q, ks_cnt_d;

    always_comb begin
        dp_cnt_d = dp_cnt_q;
        ks_cnt_d = ks_cnt_q;
        if (dp_gnt && dp_cnt_q != 16'hFFFF) begin
            dp_cnt_d = dp_cnt_q + 16'd1;
        end
        if (ks_gnt && ks_cnt_q != 16'hFFFF) begin
            ks_cnt_d = ks_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_cnt_q <= '0;
            ks_cnt_q <= '0;
        end else begin
            dp_cnt_q <= dp_cnt_d;
            ks_cnt_q <= ks_cnt_d;
        end
    end

    assign dp_grant_cnt = dp_cnt_q;
    assign ks_grant_cnt = ks_cnt_q;
`endif

endmodule
